// File: rtl/card_regfile_arbiter.sv
// rtl/card_regfile_arbiter.sv - card register file write arbiter with one-entry pending slot and sweep read addressing
module card_regfile_arbiter #(
    parameter int NUM_CARDS = 12,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 14,
    parameter int STATE_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                full_valid,
    input  logic [ADDR_W-1:0]   full_addr,
    input  logic [DATA_W-1:0]   full_data,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [ADDR_W-1:0]   st_addr,
    input  logic [STATE_W-1:0]  st_data,
    input  logic                sweep_req,
    input  logic [ADDR_W-1:0]   single_addr,
    output logic [1:0]          rf_w_en,
    output logic [ADDR_W-1:0]   rf_w_addr,
    output logic [DATA_W-1:0]   rf_w_data,
    output logic [ADDR_W-1:0]   rf_r_addr,
    output logic                sweep_busy,
    output logic                sweep_done,
    output logic                wr_drop
);
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_CARDS);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a != '0) && (a <= LAST);
    endfunction

    typedef enum logic {S_ONE, S_SWEEP} rd_state_t;

    logic [1:0]         w_en_q, w_en_d;
    logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
    logic [DATA_W-1:0]  w_data_q, w_data_d;
    logic               drop_q, drop_d;
    logic               st_ready_q, st_ready_d;
    logic               pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic [STATE_W-1:0] pend_data_q, pend_data_d;
    logic               st_acc, full_ok, st_ok;

    rd_state_t          state_q;
    logic               again_q;
    logic [ADDR_W-1:0]  r_addr_q;
    logic               busy_q, done_q;

    always_comb begin
        st_acc       = st_valid && st_ready_q;
        full_ok      = full_valid && in_range(full_addr);
        st_ok        = st_acc && in_range(st_addr);
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        w_en_d       = 2'b00;
        w_addr_d     = '0;
        w_data_d     = '0;
        // full_valid owns the port even when its own address is dropped
        if (full_valid) begin
            if (full_ok) begin
                w_en_d   = 2'b01;
                w_addr_d = full_addr;
                w_data_d = full_data;
            end
            if (st_ok) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = st_addr;
                pend_data_d  = st_data;
            end
        end else if (pend_valid_q) begin
            w_en_d       = 2'b10;
            w_addr_d     = pend_addr_q;
            w_data_d     = {{(DATA_W-STATE_W){1'b0}}, pend_data_q};
            pend_valid_d = 1'b0;
        end else if (st_ok) begin
            w_en_d   = 2'b10;
            w_addr_d = st_addr;
            w_data_d = {{(DATA_W-STATE_W){1'b0}}, st_data};
        end
        drop_d     = (full_valid && !full_ok) || (st_acc && !st_ok);
        // ready stays low through the drain cycle and returns one cycle later
        st_ready_d = !(pend_valid_q || pend_valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_en_q       <= 2'b00;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            drop_q       <= 1'b0;
            st_ready_q   <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            drop_q       <= drop_d;
            st_ready_q   <= st_ready_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_ONE;
            again_q  <= 1'b0;
            r_addr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_ONE: begin
                    if (sweep_req) begin
                        state_q  <= S_SWEEP;
                        r_addr_q <= FIRST;
                        busy_q   <= 1'b1;
                    end else begin
                        r_addr_q <= single_addr;
                        busy_q   <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (r_addr_q == LAST) begin
                        done_q <= 1'b1;
                        // a request arriving on the final address merges into the restart
                        if (again_q || sweep_req) begin
                            r_addr_q <= FIRST;
                            again_q  <= 1'b0;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q  <= S_ONE;
                            r_addr_q <= single_addr;
                            busy_q   <= 1'b0;
                        end
                    end else begin
                        r_addr_q <= r_addr_q + FIRST;
                        again_q  <= again_q | sweep_req;
                        busy_q   <= 1'b1;
                    end
                end
                default: state_q <= S_ONE;
            endcase
        end
    end

    assign rf_w_en    = w_en_q;
    assign rf_w_addr  = w_addr_q;
    assign rf_w_data  = w_data_q;
    assign wr_drop    = drop_q;
    assign st_ready   = st_ready_q;
    assign rf_r_addr  = r_addr_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_card_regfile_arbiter.sv
// tb/tb_card_regfile_arbiter.sv - self-checking bench for card_regfile_arbiter
module tb_card_regfile_arbiter;
    localparam int NUM = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        full_valid = 1'b0;
    logic [3:0]  full_addr = '0;
    logic [13:0] full_data = '0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [3:0]  st_addr = '0;
    logic [1:0]  st_data = '0;
    logic        sweep_req = 1'b0;
    logic [3:0]  single_addr = '0;
    logic [1:0]  rf_w_en;
    logic [3:0]  rf_w_addr;
    logic [13:0] rf_w_data;
    logic [3:0]  rf_r_addr;
    logic        sweep_busy, sweep_done, wr_drop;

    card_regfile_arbiter #(.NUM_CARDS(NUM), .ADDR_W(4), .DATA_W(14), .STATE_W(2)) dut (
        .clk(clk), .rst(rst),
        .full_valid(full_valid), .full_addr(full_addr), .full_data(full_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .sweep_req(sweep_req), .single_addr(single_addr),
        .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
        .rf_r_addr(rf_r_addr), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [1:0] s;
    } pend_t;

    pend_t       pq[$];
    logic        m_ready;
    int          cur;
    logic        queued;
    logic [1:0]  e_en;
    logic [3:0]  e_wa;
    logic [13:0] e_wd;
    logic        e_drop, e_busy, e_done;
    logic [3:0]  e_raddr;

    typedef struct {
        logic        fv;
        logic [3:0]  fa;
        logic [13:0] fd;
        logic        sv;
        logic [3:0]  sa;
        logic [1:0]  sd;
        logic [1:0]  en;
        logic [3:0]  wa;
        logic [13:0] wd;
        logic        drop;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit inr(input logic [3:0] a);
        return (int'(a) >= 1) && (int'(a) <= NUM);
    endfunction

    // One clock: predict outputs from the rules, advance, compare.
    task automatic tick();
        int    sz0;
        bit    acc;
        pend_t p;
        e_en = 2'b00; e_wa = '0; e_wd = '0; e_drop = 1'b0; e_done = 1'b0;
        if (rst) begin
            pq.delete();
            m_ready = 1'b1;
            cur     = 0;
            queued  = 1'b0;
        end else begin
            sz0 = pq.size();
            acc = st_valid && m_ready;
            e_drop = (full_valid && !inr(full_addr)) || (acc && !inr(st_addr));
            if (acc && inr(st_addr)) begin
                p.a = st_addr;
                p.s = st_data;
                pq.push_back(p);
            end
            if (full_valid) begin
                if (inr(full_addr)) begin
                    e_en = 2'b01; e_wa = full_addr; e_wd = full_data;
                end
            end else if (pq.size() > 0) begin
                p = pq.pop_front();
                e_en = 2'b10; e_wa = p.a; e_wd = {12'b0, p.s};
            end
            m_ready = (sz0 == 0) && (pq.size() == 0);
            if (cur == 0) begin
                if (sweep_req) cur = 1;
            end else if (cur < NUM) begin
                cur++;
                queued = queued | sweep_req;
            end else begin
                e_done = 1'b1;
                if (queued || sweep_req) begin
                    cur = 1;
                    queued = 1'b0;
                end else begin
                    cur = 0;
                end
            end
        end
        e_busy  = (cur != 0);
        e_raddr = rst ? 4'd0 : ((cur != 0) ? 4'(cur) : single_addr);
        @(posedge clk);
        #1;
        chk("w_en", rf_w_en, e_en);
        if (e_en != 2'b00) begin
            chk("w_addr", rf_w_addr, e_wa);
            chk("w_data", rf_w_data, e_wd);
        end
        chk("en_onehot", (rf_w_en == 2'b11), 0);
        chk("wr_drop", wr_drop, e_drop);
        chk("st_ready", st_ready, m_ready);
        chk("r_addr", rf_r_addr, e_raddr);
        chk("busy", sweep_busy, e_busy);
        chk("done", sweep_done, e_done);
    endtask

    task automatic idle_inputs();
        full_valid = 1'b0; st_valid = 1'b0; sweep_req = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd3,  14'h1A5C, 1'b0, 4'd0,  2'd0, 2'b01, 4'd3,  14'h1A5C, 1'b0};
        vecs[1] = '{1'b0, 4'd0,  14'h0000, 1'b1, 4'd7,  2'd3, 2'b10, 4'd7,  14'h0003, 1'b0};
        vecs[2] = '{1'b1, 4'd0,  14'h1111, 1'b0, 4'd0,  2'd0, 2'b00, 4'd0,  14'h0000, 1'b1};
        vecs[3] = '{1'b1, 4'd13, 14'h2222, 1'b0, 4'd0,  2'd0, 2'b00, 4'd0,  14'h0000, 1'b1};
        vecs[4] = '{1'b0, 4'd0,  14'h0000, 1'b1, 4'd0,  2'd1, 2'b00, 4'd0,  14'h0000, 1'b1};
        vecs[5] = '{1'b0, 4'd0,  14'h0000, 1'b1, 4'd13, 2'd1, 2'b00, 4'd0,  14'h0000, 1'b1};
        vecs[6] = '{1'b1, 4'd12, 14'h3FFF, 1'b0, 4'd0,  2'd0, 2'b01, 4'd12, 14'h3FFF, 1'b0};
        vecs[7] = '{1'b0, 4'd0,  14'h0000, 1'b1, 4'd1,  2'd2, 2'b10, 4'd1,  14'h0002, 1'b0};
        vecs[8] = '{1'b1, 4'd15, 14'h0AAA, 1'b1, 4'd14, 2'd3, 2'b00, 4'd0,  14'h0000, 1'b1};
        vecs[9] = '{1'b1, 4'd1,  14'h0155, 1'b1, 4'd0,  2'd1, 2'b01, 4'd1,  14'h0155, 1'b1};

        // Reset
        rst = 1'b1;
        tick();
        chk("rst_en", rf_w_en, 0);
        chk("rst_ready", st_ready, 1);
        chk("rst_raddr", rf_r_addr, 0);
        tick();
        rst = 1'b0;
        tick();

        // Table-driven single-cycle writes from idle
        for (int i = 0; i < 10; i++) begin
            full_valid = vecs[i].fv; full_addr = vecs[i].fa; full_data = vecs[i].fd;
            st_valid = vecs[i].sv; st_addr = vecs[i].sa; st_data = vecs[i].sd;
            tick();
            chk("vec_en", rf_w_en, vecs[i].en);
            if (vecs[i].en != 2'b00) begin
                chk("vec_addr", rf_w_addr, vecs[i].wa);
                chk("vec_data", rf_w_data, vecs[i].wd);
            end
            chk("vec_drop", wr_drop, vecs[i].drop);
            idle_inputs();
            tick();
        end

        // Same-address collision parks the state write
        full_valid = 1'b1; full_addr = 4'd5; full_data = 14'h2ABC;
        st_valid = 1'b1; st_addr = 4'd5; st_data = 2'b10;
        tick();
        chk("col_en1", rf_w_en, 2'b01);
        chk("col_addr1", rf_w_addr, 5);
        chk("col_ready1", st_ready, 0);
        idle_inputs();
        tick();
        chk("col_en2", rf_w_en, 2'b10);
        chk("col_addr2", rf_w_addr, 5);
        chk("col_data2", rf_w_data, 14'h0002);
        tick();
        chk("col_ready3", st_ready, 1);

        // Four back-to-back full writes starve the parked write
        for (int i = 0; i < 4; i++) begin
            full_valid = 1'b1; full_addr = 4'(2 + i); full_data = 14'(i * 37);
            st_valid = (i == 0); st_addr = 4'd9; st_data = 2'b01;
            tick();
            chk("starve_en", rf_w_en, 2'b01);
            chk("starve_ready", st_ready, 0);
        end
        idle_inputs();
        tick();
        chk("drain_en", rf_w_en, 2'b10);
        chk("drain_addr", rf_w_addr, 9);
        chk("drain_data", rf_w_data, 14'h0001);
        chk("drain_ready", st_ready, 0);
        tick();
        chk("drain_ready2", st_ready, 1);

        // Plain sweep with single_addr = 7
        single_addr = 4'd7;
        tick();
        sweep_req = 1'b1;
        for (int t = 1; t <= NUM; t++) begin
            tick();
            sweep_req = 1'b0;
            chk("sw_addr", rf_r_addr, t);
            chk("sw_busy", sweep_busy, 1);
        end
        tick();
        chk("sw_done", sweep_done, 1);
        chk("sw_ret", rf_r_addr, 7);
        chk("sw_idle", sweep_busy, 0);

        // Repeated requests merge into one restart; reset aborts the second sweep
        sweep_req = 1'b1;
        tick();
        for (int t = 1; t <= NUM; t++) begin
            chk("rs_addr", rf_r_addr, t);
            sweep_req = (t == 4 || t == 6);
            tick();
        end
        sweep_req = 1'b0;
        chk("rs_addr1", rf_r_addr, 1);
        chk("rs_done", sweep_done, 1);
        chk("rs_busy", sweep_busy, 1);
        for (int t = 2; t <= 8; t++) tick();
        chk("rs_addr8", rf_r_addr, 8);
        rst = 1'b1;
        tick();
        chk("rs_rst_addr", rf_r_addr, 0);
        chk("rs_rst_busy", sweep_busy, 0);
        rst = 1'b0;
        for (int t = 0; t < NUM + 3; t++) begin
            tick();
            chk("rs_nobusy", sweep_busy, 0);
            chk("rs_nodone", sweep_done, 0);
        end

        // Randomised traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            full_valid  = ($urandom_range(0, 99) < 40);
            full_addr   = 4'($urandom_range(0, 15));
            full_data   = 14'($urandom);
            st_valid    = ($urandom_range(0, 1) == 1);
            st_addr     = 4'($urandom_range(0, 15));
            st_data     = 2'($urandom);
            sweep_req   = ($urandom_range(0, 99) < 6);
            single_addr = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/card_regfile_arbiter.md
# card_regfile_arbiter

Parametrised controller between game logic and the card register file. It arbitrates two write channels onto the register file write port:

- a full-record channel, which carries card data plus card state;
- a state-only channel, which carries card state bits only.

Unlike a purely combinational mux, it never loses a colliding write: a collision is parked in a one-entry pending slot. The block also produces the read address, switching between a single-card lookup and a full sweep of the card indices. Sweep requests that arrive mid-sweep are queued, not dropped.

## Interface

Parameters:
- NUM_CARDS, 12: highest valid card index; valid indices are 1..NUM_CARDS.
- ADDR_W, 4: address width; must hold NUM_CARDS.
- DATA_W, 14: full record width; bits [STATE_W-1:0] are the card state.
- STATE_W, 2: card state width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- full_valid  in  1  full-record write request; always accepted.
- full_addr  in  ADDR_W  full-record target index.
- full_data  in  DATA_W  full-record payload.
- st_valid  in  1  state-only write request.
- st_ready  out  1  state channel can accept; transfer when st_valid&&st_ready.
- st_addr  in  ADDR_W  state-only target index.
- st_data  in  STATE_W  new card state.
- sweep_req  in  1  request a sweep of indices 1..NUM_CARDS.
- single_addr  in  ADDR_W  index to read when not sweeping.
- rf_w_en  out  2  [0] write all DATA_W bits; [1] write [STATE_W-1:0] only.
- rf_w_addr  out  ADDR_W  register file write index.
- rf_w_data  out  DATA_W  write data; upper bits 0 on a state-only write.
- rf_r_addr  out  ADDR_W  register file read index.
- sweep_busy  out  1  a sweep address is on rf_r_addr this cycle.
- sweep_done  out  1  one-cycle pulse after the last sweep address.
- wr_drop  out  1  one-cycle pulse when an out-of-range write is discarded.

## Operation

Write path. All outputs are registered.

- In-range means 1 ≤ addr ≤ NUM_CARDS. An accepted out-of-range request is discarded, raises wr_drop, and leaves rf_w_en at 0 for that request. If both channels drop in the same cycle, a single wr_drop pulse covers both.
- Priority in any cycle is: full write, then pending slot, then newly accepted state write.
- Full write: rf_w_en=2'b01, with full_addr and full_data.
- Issued state write (pending or new): rf_w_en=2'b10, rf_w_data={zeros, st_data}.
- A state write accepted in a cycle where full_valid=1 goes into the pending slot.
- Pending slot behaviour:
  - While the slot is occupied, st_ready=0.
  - The slot drains in the first cycle without full_valid.
  - Sustained full_valid may starve the slot; this is permitted.
- Same-address collision: the full write lands first and the state write one or more cycles later. The final state bits are therefore st_data.
- rf_w_en never has both bits set.

Read path. FSM with two states, ONE and SWEEP.

- ONE state:
  - rf_r_addr <= single_addr each cycle.
  - If sweep_req=1, go to SWEEP with rf_r_addr <= 1.
- SWEEP state:
  - rf_r_addr increments by 1 each cycle.
  - At rf_r_addr==NUM_CARDS, the next cycle sets sweep_done=1.
  - If a sweep request is queued (again=1), that same cycle restarts at address 1, clears again and stays in SWEEP.
  - Otherwise that cycle returns to ONE with rf_r_addr <= single_addr.
- sweep_req while in SWEEP sets the one-bit again flag. Multiple requests merge into one.
- sweep_req on the exact cycle that sweep_done is set counts as a queued request, not as a new request from ONE.
- The address counter never exceeds NUM_CARDS; there is no wrap to 0.

## Timing

- Reset values:
  - rf_w_en=0, rf_w_addr=0, rf_w_data=0.
  - rf_r_addr=0, state ONE, again=0, pending empty.
  - st_ready=1, sweep_busy=0, sweep_done=0, wr_drop=0.
- Write latency: request in cycle t gives rf_w_* valid in cycle t+1. A parked state write appears no earlier than t+2.
- st_ready is registered; it falls in the cycle after parking and rises in the cycle after draining.
- Sweep latency: sweep_req in cycle t gives rf_r_addr=1 at t+1 and NUM_CARDS at t+NUM_CARDS. sweep_done is high only at t+NUM_CARDS+1.
- sweep_busy is high exactly for cycles t+1..t+NUM_CARDS. A back-to-back restart keeps it high continuously.
- rst mid-operation aborts the sweep, clears the queued request and discards the pending write. No write output is issued in the cycle after rst.

## Test plan

- Full write addr 3, data 14'h1A5C -> next cycle rf_w_en=01, rf_w_addr=3, rf_w_data=14'h1A5C.
- full_valid (addr 5) with st_valid (addr 5, st_data=2'b10) in the same cycle:
  - cycle +1: en=01, addr 5, st_ready=0;
  - cycle +2: en=10, addr 5, data=14'h0002;
  - cycle +3: st_ready=1.
- Full writes on 4 consecutive cycles with one parked state write -> the state write issues in the first idle cycle and st_ready stays 0 until then.
- Write to addr 0 and addr 13 (NUM_CARDS=12) -> wr_drop pulses and rf_w_en stays 0.
- sweep_req at t=0, single_addr=7:
  - rf_r_addr = 1,2,...,12 at t=1..12;
  - sweep_done and rf_r_addr=7 at t=13.
- sweep_req repeated at t=4 and t=6 during a sweep -> exactly one back-to-back restart, addr 12 then 1 with sweep_done=1. rst at t=8 of the second sweep -> rf_r_addr=0, busy=0 and no further sweep.
